// File: rtl/serial_paralelo_param.sv
// Serial-to-parallel receiver: COM search, lock qualification and WIDTH-bit
// deserialisation on the single fast bit clock, with IDL substituted for COM.
// Ports: clk_32f (bit clock), reset (async, active-low), data_in (serial, MSB
// first), active (locked), word_strobe (pulse after each boundary outside
// SEARCH), valid_out (pulse for non-COM words in ACTIVE), data_out (last word),
// data2send (last word with COM replaced by IDL_SYM).
// Optional: define SERIAL_PARALELO_LOSS_OF_LOCK_EN to drop lock after
// MISALIGN_MAX COMs seen off the word boundary while ACTIVE.
module serial_paralelo_param #(
    parameter int               WIDTH        = 8,
    parameter logic [WIDTH-1:0] COM_SYM      = 8'hBC,
    parameter logic [WIDTH-1:0] IDL_SYM      = 8'h7C,
    parameter int               LOCK_COMS    = 4,
    parameter int               MISALIGN_MAX = 4
) (
    input  logic             clk_32f,
    input  logic             reset,
    input  logic             data_in,
    output logic             active,
    output logic             word_strobe,
    output logic             valid_out,
    output logic [WIDTH-1:0] data_out,
    output logic [WIDTH-1:0] data2send
);

    localparam int CW  = $clog2(WIDTH);
    localparam int FW  = $clog2(WIDTH + 1);
    localparam int CMW = $clog2(LOCK_COMS + 1);

    if (WIDTH < 4 || LOCK_COMS < 1 || MISALIGN_MAX < 1) begin : g_param_chk
        $error("serial_paralelo_param: illegal parameter value");
    end

    typedef enum logic [1:0] {
        SEARCH,
        ALIGN,
        ACTIVE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q;
    logic [CW-1:0]    bit_q, bit_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic [CMW-1:0]   com_q, com_d, com_inc;
    logic             active_d, strobe_d, valid_d;
    logic [WIDTH-1:0] dout_d, d2s_d;
    logic             sr_full, is_com, at_end, bnd;

`ifdef SERIAL_PARALELO_LOSS_OF_LOCK_EN
    localparam int MSW = $clog2(MISALIGN_MAX + 1);
    logic [MSW-1:0] mis_q, mis_d, mis_inc;
    assign mis_inc = mis_q + MSW'(1);
`endif

    // fill counts fresh bits since reset so that a COM straddling the
    // reset release can never be matched against stale zeros.
    assign sr_full = (fill_q == FW'(WIDTH));
    assign is_com  = sr_full && (sr_q == COM_SYM);
    assign at_end  = (bit_q == CW'(WIDTH - 1));
    assign bnd     = (state_q != SEARCH) && at_end;
    assign com_inc = com_q + CMW'(1);

    always_comb begin
        state_d  = state_q;
        bit_d    = at_end ? '0 : bit_q + CW'(1);
        fill_d   = sr_full ? fill_q : fill_q + FW'(1);
        com_d    = com_q;
        active_d = active;
        strobe_d = 1'b0;
        valid_d  = 1'b0;
        dout_d   = data_out;
        d2s_d    = data2send;
`ifdef SERIAL_PARALELO_LOSS_OF_LOCK_EN
        mis_d    = mis_q;
`endif
        unique case (state_q)
            SEARCH: begin
                if (is_com) begin
                    bit_d = '0;
                    com_d = CMW'(1);
                    if (LOCK_COMS == 1) begin
                        state_d  = ACTIVE;
                        active_d = 1'b1;
                    end else begin
                        state_d = ALIGN;
                    end
                end
            end
            ALIGN: begin
                if (bnd) begin
                    strobe_d = 1'b1;
                    if (is_com) begin
                        com_d = com_inc;
                        if (com_inc == CMW'(LOCK_COMS)) begin
                            state_d  = ACTIVE;
                            active_d = 1'b1;
                        end
                    end else begin
                        state_d = SEARCH;
                        com_d   = '0;
                    end
                end
            end
            ACTIVE: begin
                if (bnd) begin
                    strobe_d = 1'b1;
                    dout_d   = sr_q;
                    if (is_com) begin
                        d2s_d = IDL_SYM;
                    end else begin
                        d2s_d   = sr_q;
                        valid_d = 1'b1;
                    end
                end
`ifdef SERIAL_PARALELO_LOSS_OF_LOCK_EN
                if (bnd && is_com) begin
                    mis_d = '0;
                end else if (is_com) begin
                    if (mis_inc == MSW'(MISALIGN_MAX)) begin
                        state_d  = SEARCH;
                        active_d = 1'b0;
                        mis_d    = '0;
                        com_d    = '0;
                    end else begin
                        mis_d = mis_inc;
                    end
                end
`endif
            end
            default: begin
                state_d = SEARCH;
            end
        endcase
    end

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            state_q     <= SEARCH;
            sr_q        <= '0;
            bit_q       <= '0;
            fill_q      <= '0;
            com_q       <= '0;
            active      <= 1'b0;
            word_strobe <= 1'b0;
            valid_out   <= 1'b0;
            data_out    <= '0;
            data2send   <= '0;
        end else begin
            state_q     <= state_d;
            sr_q        <= {sr_q[WIDTH-2:0], data_in};
            bit_q       <= bit_d;
            fill_q      <= fill_d;
            com_q       <= com_d;
            active      <= active_d;
            word_strobe <= strobe_d;
            valid_out   <= valid_d;
            data_out    <= dout_d;
            data2send   <= d2s_d;
        end
    end

`ifdef SERIAL_PARALELO_LOSS_OF_LOCK_EN
    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            mis_q <= '0;
        end else begin
            mis_q <= mis_d;
        end
    end
`endif

endmodule

// File: tb/tb_serial_paralelo_param.sv
// Testbench for serial_paralelo_param: directed lock/data/reset scenarios
// plus randomized bit streams checked against a word-level reference model.
module tb_serial_paralelo_param;

    localparam int         W    = 8;
    localparam logic [7:0] COM  = 8'hBC;
    localparam logic [7:0] IDL  = 8'h7C;
    localparam int         LOCK = 4;
    localparam int         MAXM = 4;

    logic       clk_32f = 1'b0;
    logic       reset;
    logic       data_in;
    logic       active;
    logic       word_strobe;
    logic       valid_out;
    logic [7:0] data_out;
    logic [7:0] data2send;

    int n_cmp = 0;
    int n_bad = 0;
    int n_stb = 0;
    int n_vld = 0;

    serial_paralelo_param #(
        .WIDTH        (W),
        .COM_SYM      (COM),
        .IDL_SYM      (IDL),
        .LOCK_COMS    (LOCK),
        .MISALIGN_MAX (MAXM)
    ) dut (
        .clk_32f     (clk_32f),
        .reset       (reset),
        .data_in     (data_in),
        .active      (active),
        .word_strobe (word_strobe),
        .valid_out   (valid_out),
        .data_out    (data_out),
        .data2send   (data2send)
    );

    always #5 clk_32f = ~clk_32f;

    // reference model: link mode, position of the aligning COM,
    // and the bits received since reset
    bit   hist[$];
    int   mode;
    int   cyc;
    int   anchor;
    int   coms;
    int   mis;
    logic m_act, m_stb, m_vld;
    logic [7:0] m_dout, m_d2s;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        mode   = 0;
        cyc    = 0;
        anchor = 0;
        coms   = 0;
        mis    = 0;
        m_act  = 0;
        m_stb  = 0;
        m_vld  = 0;
        m_dout = 0;
        m_d2s  = 0;
    endtask

    task automatic model_edge(input logic b);
        logic [7:0] word;
        bit full, com, bnd;
        word = 0;
        full = hist.size() >= W;
        if (full)
            for (int i = 0; i < W; i++)
                word = {word[6:0], hist[hist.size() - W + i]};
        com   = full && (word == COM);
        bnd   = (mode != 0) && (((cyc - anchor) % W) == 0);
        m_stb = 0;
        m_vld = 0;
        if (mode == 0) begin
            if (com) begin
                anchor = cyc;
                coms   = 1;
                mode   = (LOCK == 1) ? 2 : 1;
                if (LOCK == 1) m_act = 1;
            end
        end else if (mode == 1) begin
            if (bnd) begin
                m_stb = 1;
                if (com) begin
                    coms++;
                    if (coms == LOCK) begin
                        mode  = 2;
                        m_act = 1;
                    end
                end else begin
                    mode = 0;
                    coms = 0;
                end
            end
        end else begin
            if (bnd) begin
                m_stb  = 1;
                m_dout = word;
                m_d2s  = com ? IDL : word;
                m_vld  = !com;
            end
`ifdef SERIAL_PARALELO_LOSS_OF_LOCK_EN
            if (bnd && com) mis = 0;
            else if (com) begin
                mis++;
                if (mis == MAXM) begin
                    mode  = 0;
                    m_act = 0;
                    mis   = 0;
                    coms  = 0;
                end
            end
`endif
        end
        hist.push_back(b);
        if (hist.size() > W) void'(hist.pop_front());
        cyc++;
    endtask

    task automatic compare_all();
        check("active", active, m_act);
        check("word_strobe", word_strobe, m_stb);
        check("valid_out", valid_out, m_vld);
        check("data_out", data_out, m_dout);
        check("data2send", data2send, m_d2s);
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".active"}, active, 0);
        check({tag, ".strobe"}, word_strobe, 0);
        check({tag, ".valid"}, valid_out, 0);
        check({tag, ".data_out"}, data_out, 0);
        check({tag, ".data2send"}, data2send, 0);
    endtask

    task automatic step(input logic b);
        data_in = b;
        @(posedge clk_32f);
        model_edge(b);
        #1;
        compare_all();
        if (word_strobe) n_stb++;
        if (valid_out) n_vld++;
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int i = W - 1; i >= 0; i--) step(w[i]);
    endtask

    task automatic hold_reset(input int n);
        reset = 1'b0;
        model_reset();
        #1;
        check_zero("rst_now");
        for (int i = 0; i < n; i++) begin
            data_in = 1'($urandom);
            @(posedge clk_32f);
            #1;
            check_zero("rst_hold");
        end
        reset = 1'b1;
    endtask

    initial begin
        logic [7:0] junk;
        int r;
        data_in = 1'b0;
        reset   = 1'b0;
        model_reset();
        @(posedge clk_32f);
        #1;
        hold_reset(10);

        junk = 8'b010;
        for (int i = 2; i >= 0; i--) step(junk[i]);
        repeat (4) send_word(COM);
        check("lock_not_early", active, 0);
        n_stb = 0;
        n_vld = 0;
        send_word(8'h55);
        check("lock_rise", active, 1);
        send_word(COM);
        check("dout_55", data_out, 8'h55);
        check("d2s_55", data2send, 8'h55);
        send_word(8'hA3);
        check("dout_bc", data_out, 8'hBC);
        check("d2s_idl", data2send, 8'h7C);
        send_word(8'h00);
        check("dout_a3", data_out, 8'hA3);
        check("d2s_a3", data2send, 8'hA3);
        check("strobe_cnt", n_stb, 4);
        check("valid_cnt", n_vld, 2);

        hold_reset(2);
        send_word(COM);
        send_word(COM);
        send_word(8'h00);
        repeat (4) send_word(COM);
        check("relock_not_early", active, 0);
        send_word(8'h5A);
        check("relock_rise", active, 1);

        step(1'b1);
        step(1'b0);
        step(1'b1);
        hold_reset(2);
        step(1'b1);
        step(1'b1);
        step(1'b1);
        step(1'b0);
        step(1'b0);
        repeat (4) send_word(COM);
        check("straddle_not_early", active, 0);
        step(1'b0);
        check("straddle_lock", active, 1);

        send_word(8'h00);
        step(1'b0);
        repeat (4) send_word(COM);
        check("misalign_pre", active, 1);
        step(1'b0);
`ifdef SERIAL_PARALELO_LOSS_OF_LOCK_EN
        check("misalign_drop", active, 0);
`else
        check("misalign_sticky", active, 1);
`endif

        hold_reset(3);
        for (int it = 0; it < 700; it++) begin
            r = $urandom_range(0, 19);
            if (r < 8) send_word(COM);
            else if (r < 14) send_word(8'($urandom));
            else if (r < 18) step(1'($urandom));
            else if (r == 18) send_word(IDL);
            else if ($urandom_range(0, 3) == 0) hold_reset($urandom_range(1, 3));
            else send_word(8'h00);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
